mul_ctrl: RTL and testbench

MUL_CTRL -- requirements
Module: mul_ctrl

---
 rtl/mul_ctrl.sv | 114 +++++++++++
 tb/tb_mul_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_ctrl.sv
// Sequencer for an external 34x34 Booth multiplier handling mul.w / mulh.w / mulh.wu.
// Define MUL_ZERO_SKIP_EN to finish zero-operand ops in one cycle without using the multiplier.
module mul_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [33:0] mul_x,
    output logic [33:0] mul_y,
    input  logic [67:0] mul_z
);

    typedef enum logic [1:0] {StIdle, StCalc1, StCalc2, StDone} state_e;

    state_e      state_q;
    logic [1:0]  op_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [31:0] result_q;

    logic        accept;
    logic        op_signed;
    logic        op_high;
    logic        start_skip;
    logic        unused_z;

    assign in_ready = ((state_q == StIdle) || ((state_q == StDone) && out_ready)) && !flush;
    assign accept   = in_valid && in_ready;

    assign out_valid  = (state_q == StDone) && !flush;
    assign out_result = result_q;

    // Only mulh.wu is unsigned; the reserved encoding behaves as mul.w.
    assign op_signed = (op_q != 2'b10);
    assign op_high   = (op_q == 2'b01) || (op_q == 2'b10);

    assign mul_x = {{2{op_signed & src1_q[31]}}, src1_q};
    assign mul_y = {{2{op_signed & src2_q[31]}}, src2_q};

    // Bits above 63 are only sign extension of the 66-bit product.
    assign unused_z = ^mul_z[67:64];

`ifdef MUL_ZERO_SKIP_EN
    assign start_skip = (in_src1 == 32'h0) || (in_src2 == 32'h0);
`else
    assign start_skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            op_q     <= 2'b00;
            src1_q   <= 32'h0;
            src2_q   <= 32'h0;
            result_q <= 32'h0;
        end else begin
            if (accept) begin
                op_q   <= in_op;
                src1_q <= in_src1;
                src2_q <= in_src2;
            end

            if (flush) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            if (start_skip) begin
                                state_q  <= StDone;
                                result_q <= 32'h0;
                            end else begin
                                state_q <= StCalc1;
                            end
                        end
                    end
                    StCalc1: begin
                        state_q <= StCalc2;
                    end
                    StCalc2: begin
                        state_q  <= StDone;
                        result_q <= op_high ? mul_z[63:32] : mul_z[31:0];
                    end
                    StDone: begin
                        // Holding here with out_ready low keeps the result on the output.
                        if (out_ready) begin
                            if (accept) begin
                                if (start_skip) begin
                                    state_q  <= StDone;
                                    result_q <= 32'h0;
                                end else begin
                                    state_q <= StCalc1;
                                end
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl with an ideal combinational multiplier model.
module tb_mul_ctrl;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [33:0] mul_x;
    logic [33:0] mul_y;
    logic [67:0] mul_z;

    logic [67:0] ext_x;
    logic [67:0] ext_y;

    int checks;
    int errors;

    mul_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_z      (mul_z)
    );

    assign ext_x = {{34{mul_x[33]}}, mul_x};
    assign ext_y = {{34{mul_y[33]}}, mul_y};
    assign mul_z = ext_x * ext_y;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        if (op == 2'b10) begin
            ea = {32'h0, a};
            eb = {32'h0, b};
        end else begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
        end
        p = ea * eb;
        return (op == 2'b01 || op == 2'b10) ? p[63:32] : p[31:0];
    endfunction

    function automatic int latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_SKIP_EN
        return (a == 32'h0 || b == 32'h0) ? 1 : 3;
`else
        return (a == b) ? 3 : 3;
`endif
    endfunction

    function automatic logic [33:0] ext_operand(input logic [1:0] op, input logic [31:0] v);
        return (op == 2'b10) ? {2'b00, v} : {{2{v[31]}}, v};
    endfunction

    // One op from idle with out_ready high; checks exact latency and the result.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        int          lat;
        logic [31:0] exp;
        exp = ref_mul(op, a, b);
        lat = latency(a, b);
        @(negedge clk);
        check({name, " in_ready idle"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_op     = op;
        in_src1   = a;
        in_src2   = b;
        out_ready = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (k < lat) begin
                check({name, " early out_valid"}, 64'(out_valid), 64'd0);
            end else begin
                check({name, " out_valid"}, 64'(out_valid), 64'd1);
                check({name, " out_result"}, 64'(out_result), 64'(exp));
            end
            if (k == 1 && lat == 3) begin
                check({name, " mul_x"}, 64'(mul_x), 64'(ext_operand(op, a)));
                check({name, " mul_y"}, 64'(mul_y), 64'(ext_operand(op, b)));
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        checks    = 0;
        errors    = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_src1   = 32'h0;
        in_src2   = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;

        vecs.push_back('{2'b00, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFA, "mulw_3xm2"});
        vecs.push_back('{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, "mulhw_min"});
        vecs.push_back('{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhwu_max"});
        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulhw_m1"});
        vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFB, "reserved_op"});
        vecs.push_back('{2'b00, 32'h00001234, 32'h00000000, 32'h00000000, "zero_src2"});
        vecs.push_back('{2'b10, 32'h00000000, 32'h89ABCDEF, 32'h00000000, "zero_src1"});
        vecs.push_back('{2'b01, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, "mulhw_mixed"});

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_result", 64'(out_result), 64'd0);
        check("reset mul_x", 64'(mul_x), 64'd0);
        check("reset mul_y", 64'(mul_y), 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name);
        end

        // Backpressure: result held five cycles, consumed once.
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_src1   = 32'd5;
        in_src2   = 32'd9;
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        for (int h = 0; h < 5; h++) begin
            in_valid = 1'b1;
            in_src1  = 32'd2;
            in_src2  = 32'd3;
            #1;
            check("hold out_valid", 64'(out_valid), 64'd1);
            check("hold out_result", 64'(out_result), 64'd45);
            check("hold in_ready", 64'(in_ready), 64'd0);
            if (h < 4) @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("consumed once out_valid", 64'(out_valid), 64'd0);
        check("after consume in_ready", 64'(in_ready), 64'd1);

        // Reset during CALC1 with a live result in the register.
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_src1  = 32'd11;
        in_src2  = 32'd13;
        @(negedge clk);
        in_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset out_result", 64'(out_result), 64'd0);
        check("midreset mul_x", 64'(mul_x), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op(2'b00, 32'd3, 32'd4, "post_reset");

        // Back-to-back: second op accepted in the cycle the first is consumed.
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_src1   = 32'd7;
        in_src2   = 32'd6;
        out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_op   = 2'b10;
                in_src1 = 32'h00010000;
                in_src2 = 32'h00010000;
            end
            if (k == 4) in_valid = 1'b0;
            #1;
            if (k == 3) begin
                check("b2b first out_valid", 64'(out_valid), 64'd1);
                check("b2b first result", 64'(out_result), 64'd42);
                check("b2b in_ready", 64'(in_ready), 64'd1);
            end else if (k == 6) begin
                check("b2b second out_valid", 64'(out_valid), 64'd1);
                check("b2b second result", 64'(out_result), 64'd1);
            end else begin
                check("b2b gap out_valid", 64'(out_valid), 64'd0);
                check("b2b gap in_ready", 64'(in_ready), 64'd0);
            end
        end

        // Flush in CALC2.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_src1  = 32'd21;
        in_src2  = 32'd2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush calc2 in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush calc2 next in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            check("flush calc2 no out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
            #1;
        end

        // Flush in DONE while backpressured.
        in_valid  = 1'b1;
        in_src1   = 32'd8;
        in_src2   = 32'd8;
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #1;
        check("done before flush out_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        #1;
        check("flush done out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("flush done next out_valid", 64'(out_valid), 64'd0);
        check("flush done next in_ready", 64'(in_ready), 64'd1);

        // Flush together with in_valid must not accept.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_src1  = 32'd9;
        in_src2  = 32'd9;
        #1;
        check("flush accept in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush accept not taken", 64'(in_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("flush accept no out_valid", 64'(out_valid), 64'd0);
        end

        // Randomized ops against the arithmetic reference.
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            run_op(rop, ra, rb, "random");
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
